// File: rtl/spi_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_decoder_if
// Purpose  : Byte-receiver inputs and committed-frame outputs of the decoder.
// Revision : 1.0
// ============================================================================
interface spi_frame_decoder_if #(
    parameter int FRAME_BYTES = 11
);
    logic                       ssel;
    logic [7:0]                 rx_byte;
    logic                       rx_valid;
    logic [8*FRAME_BYTES-1:0]   frame_data;
    logic                       frame_strobe;
    logic                       crc_err;
    logic                       len_err;
    logic [7:0]                 frame_cnt;
    logic [7:0]                 err_cnt;

    modport master (
        output ssel, rx_byte, rx_valid,
        input  frame_data, frame_strobe, crc_err, len_err, frame_cnt, err_cnt
    );

    modport slave (
        input  ssel, rx_byte, rx_valid,
        output frame_data, frame_strobe, crc_err, len_err, frame_cnt, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_decoder
// Purpose  : Collects one chip-select window of bytes, checks length and
//            additive checksum, and commits only good frames.
// Revision : 1.0
// ============================================================================
module spi_frame_decoder #(
    parameter int FRAME_BYTES = 11
) (
    input  logic               clk50M,
    input  logic               rst_n,
    spi_frame_decoder_if.slave bus
);
    localparam int CNT_W   = $clog2(FRAME_BYTES + 2);
    localparam int FRAME_W = 8 * FRAME_BYTES;

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state_q,        state_d;
    logic               ssel_meta_q,    ssel_meta_d;
    logic               ssel_s_q,       ssel_s_d;
    logic [1:0]         sync_vld_q,     sync_vld_d;
    logic               armed_q,        armed_d;
    logic [CNT_W-1:0]   cnt_q,          cnt_d;
    logic [7:0]         sum_q,          sum_d;
    logic [FRAME_W-1:0] shadow_q,       shadow_d;
    logic [FRAME_W-1:0] frame_data_q,   frame_data_d;
    logic               frame_strobe_q, frame_strobe_d;
    logic               crc_err_q,      crc_err_d;
    logic               len_err_q,      len_err_d;
    logic [7:0]         frame_cnt_q,    frame_cnt_d;
    logic [7:0]         err_cnt_q,      err_cnt_d;

    always_comb begin
        state_d        = state_q;
        ssel_meta_d    = bus.ssel;
        ssel_s_d       = ssel_meta_q;
        sync_vld_d     = {sync_vld_q[0], 1'b1};
        // Only arm once a genuine high select has passed through the synchronizer,
        // so a reset released mid-frame does not pick up the tail of that frame.
        armed_d        = armed_q | (ssel_s_q & sync_vld_q[1]);
        cnt_d          = cnt_q;
        sum_d          = sum_q;
        shadow_d       = shadow_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = 1'b0;
        crc_err_d      = 1'b0;
        len_err_d      = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        err_cnt_d      = err_cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sum_d = 8'd0;
                if (!ssel_s_q && armed_q) begin
                    state_d = RECV;
                end
            end

            RECV: begin
                if (bus.rx_valid) begin
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shadow_d[8*(FRAME_BYTES-1-i) +: 8] = bus.rx_byte;
                        end
                    end
                    if (cnt_q < c_cnt_last) begin
                        sum_d = sum_q + bus.rx_byte;
                    end
                    if (cnt_q != c_cnt_max) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (ssel_s_q) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                state_d = IDLE;
                if (cnt_q == '0) begin
                    // empty select window: nothing to report
                end else if (cnt_q != c_cnt_full) begin
                    len_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else if (sum_q != shadow_q[7:0]) begin
                    crc_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    frame_data_d   = shadow_q;
                    frame_strobe_d = 1'b1;
                    frame_cnt_d    = frame_cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ssel_meta_q    <= 1'b1;
            ssel_s_q       <= 1'b1;
            sync_vld_q     <= 2'b00;
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            sum_q          <= 8'd0;
            shadow_q       <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= 1'b0;
            crc_err_q      <= 1'b0;
            len_err_q      <= 1'b0;
            frame_cnt_q    <= 8'd0;
            err_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            ssel_meta_q    <= ssel_meta_d;
            ssel_s_q       <= ssel_s_d;
            sync_vld_q     <= sync_vld_d;
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            sum_q          <= sum_d;
            shadow_q       <= shadow_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            crc_err_q      <= crc_err_d;
            len_err_q      <= len_err_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign bus.frame_data   = frame_data_q;
    assign bus.frame_strobe = frame_strobe_q;
    assign bus.crc_err      = crc_err_q;
    assign bus.len_err      = len_err_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.err_cnt      = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_decoder
// Purpose  : Directed frames with a queue-based scoreboard on the pulse outputs.
// Revision : 1.0
// ============================================================================
module tb_spi_frame_decoder;
    localparam int N      = 11;
    localparam int K_NONE = 0;
    localparam int K_GOOD = 1;
    localparam int K_CRC  = 2;
    localparam int K_LEN  = 3;

    logic clk50M = 1'b0;
    logic rst_n;

    spi_frame_decoder_if #(.FRAME_BYTES(N)) bus ();

    spi_frame_decoder #(.FRAME_BYTES(N)) dut (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk50M = ~clk50M;

    typedef struct {
        int             kind;
        logic [8*N-1:0] frame;
        logic [7:0]     fcnt;
        logic [7:0]     ecnt;
        int             cyc;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           mon_e;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             cyc   = 0;
    logic [7:0]     fb [0:15];
    logic [8*N-1:0] m_frame = '0;
    logic [7:0]     m_fcnt  = 8'd0;
    logic [7:0]     m_ecnt  = 8'd0;

    always @(posedge clk50M) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] pulse_code(input int kind);
        case (kind)
            K_GOOD:  return 3'b100;
            K_CRC:   return 3'b010;
            K_LEN:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Monitor: every pulse must match the oldest expected event.
    always @(posedge clk50M) begin
        #1;
        if (rst_n && (bus.frame_strobe || bus.crc_err || bus.len_err)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got %b want 000",
                         {bus.frame_strobe, bus.crc_err, bus.len_err});
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind", {125'd0, bus.frame_strobe, bus.crc_err, bus.len_err},
                    {125'd0, pulse_code(mon_e.kind)});
                chk("latency_cyc", cyc, mon_e.cyc);
                chk("frame_data", bus.frame_data, mon_e.frame);
                chk("frame_cnt", bus.frame_cnt, mon_e.fcnt);
                chk("err_cnt", bus.err_cnt, mon_e.ecnt);
            end
        end
    end

    task automatic push_exp(input int n, input int kind, input int rise_cyc);
        exp_t e;
        if (kind == K_NONE) return;
        if (kind == K_GOOD) begin
            for (int i = 0; i < N; i++) m_frame[8*(N-1-i) +: 8] = fb[i];
            m_fcnt = m_fcnt + 8'd1;
        end else if (m_ecnt != 8'hFF) begin
            m_ecnt = m_ecnt + 8'd1;
        end
        e.kind  = kind;
        e.frame = m_frame;
        e.fcnt  = m_fcnt;
        e.ecnt  = m_ecnt;
        e.cyc   = rise_cyc + 4;
        sb_q.push_back(e);
    endtask

    task automatic fill_seq(input logic [7:0] start, input logic [7:0] ck);
        for (int i = 0; i < 10; i++) fb[i] = start + 8'(i);
        fb[10] = ck;
    endtask

    // coincide: the last byte arrives in the cycle the synchronized select rises.
    task automatic send_frame(input int n, input int kind, input bit coincide, input int hi_cycles);
        bus.ssel = 1'b0;
        repeat (6) @(negedge clk50M);
        for (int i = 0; i < n; i++) begin
            if (coincide && i == n - 1) begin
                bus.ssel = 1'b1;
                push_exp(n, kind, cyc);
                repeat (2) @(negedge clk50M);
            end
            bus.rx_byte  = fb[i];
            bus.rx_valid = 1'b1;
            @(negedge clk50M);
            bus.rx_valid = 1'b0;
            if (!(coincide && i == n - 1)) @(negedge clk50M);
        end
        if (!coincide) begin
            bus.ssel = 1'b1;
            push_exp(n, kind, cyc);
        end
        repeat (hi_cycles) @(negedge clk50M);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ssel     = 1'b1;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk50M);
        chk("reset_frame_data", bus.frame_data, '0);
        chk("reset_frame_cnt", bus.frame_cnt, 8'd0);
        chk("reset_err_cnt", bus.err_cnt, 8'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk50M);

        // Good frame 01..0A, checksum 0x37
        fill_seq(8'h01, 8'h37);
        send_frame(11, K_GOOD, 1'b0, 6);
        chk("first_frame_literal", bus.frame_data, 88'h0102030405060708090A37);
        chk("first_frame_cnt", bus.frame_cnt, 8'd1);
        chk("first_err_cnt", bus.err_cnt, 8'd0);

        // Bad checksum
        fb[10] = 8'h38;
        send_frame(11, K_CRC, 1'b0, 6);
        fb[10] = 8'h37;

        // Short and long frames
        send_frame(10, K_LEN, 1'b0, 6);
        fb[11] = 8'hA5;
        send_frame(12, K_LEN, 1'b0, 6);

        // Empty select window: 20 cycles low, no bytes
        bus.ssel = 1'b0;
        repeat (20) @(negedge clk50M);
        bus.ssel = 1'b1;
        repeat (8) @(negedge clk50M);
        chk("empty_frame_cnt", bus.frame_cnt, 8'd1);
        chk("empty_err_cnt", bus.err_cnt, 8'd3);

        // Last byte coincident with select rise, sum 0x10..0x19 = 0xCD
        fill_seq(8'h10, 8'hCD);
        send_frame(11, K_GOOD, 1'b1, 6);

        // Back-to-back: select drops again one cycle after it rises
        fill_seq(8'h01, 8'h37);
        send_frame(11, K_GOOD, 1'b0, 1);
        fill_seq(8'hF0, 8'h8D);
        send_frame(11, K_GOOD, 1'b0, 6);
        chk("b2b_frame_cnt", bus.frame_cnt, 8'd4);

        // Reset after byte 5 of a frame
        fill_seq(8'h01, 8'h37);
        bus.ssel = 1'b0;
        repeat (6) @(negedge clk50M);
        for (int i = 0; i < 5; i++) begin
            bus.rx_byte = fb[i]; bus.rx_valid = 1'b1;
            @(negedge clk50M);
            bus.rx_valid = 1'b0;
            @(negedge clk50M);
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_frame_data", bus.frame_data, '0);
        chk("async_rst_frame_cnt", bus.frame_cnt, 8'd0);
        chk("async_rst_err_cnt", bus.err_cnt, 8'd0);
        m_frame = '0; m_fcnt = 8'd0; m_ecnt = 8'd0;
        @(negedge clk50M);
        rst_n = 1'b1;
        for (int i = 5; i < 11; i++) begin
            bus.rx_byte = fb[i]; bus.rx_valid = 1'b1;
            @(negedge clk50M);
            bus.rx_valid = 1'b0;
            @(negedge clk50M);
        end
        bus.ssel = 1'b1;
        repeat (8) @(negedge clk50M);
        chk("post_rst_frame_cnt", bus.frame_cnt, 8'd0);
        send_frame(11, K_GOOD, 1'b0, 6);

        // Error counter saturation: 256 single-byte frames
        fb[0] = 8'h55;
        for (int k = 0; k < 256; k++) send_frame(1, K_LEN, 1'b0, 3);
        fill_seq(8'h01, 8'h37);
        repeat (4) @(negedge clk50M);
        chk("err_cnt_saturated", bus.err_cnt, 8'hFF);

        // frame_cnt wrap: 1 + 255 good frames
        for (int k = 0; k < 255; k++) send_frame(11, K_GOOD, 1'b0, 3);
        repeat (6) @(negedge clk50M);
        chk("frame_cnt_wrapped", bus.frame_cnt, 8'd0);

        for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(negedge clk50M);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulses: got %0d pending want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
